// File: rtl/div_pkg.sv
// Shared types and constant helpers for the signed non-restoring divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} div_state_e;

  function automatic int div_latency(input int n_width, input int frac_bits);
    return n_width + frac_bits + 2;
  endfunction

  function automatic longint sat_max(input int q_width);
    return (64'sd1 <<< (q_width - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int q_width);
    return -(64'sd1 <<< (q_width - 1));
  endfunction

endpackage

// File: rtl/nr_div_core.sv
// Unsigned non-restoring divider engine: one quotient digit per busy cycle,
// digit conversion and remainder restore are combinational on the final state.
module nr_div_core #(
  parameter int NW      = 16,
  parameter int D_WIDTH = 16
) (
  input  logic               aclk,
  input  logic               resetn,
  input  logic               start,
  input  logic [NW-1:0]      dividend,
  input  logic [D_WIDTH-1:0] divisor,
  output logic               busy,
  output logic               done,
  output logic [NW-1:0]      q_mag,
  output logic [D_WIDTH-1:0] r_mag
);

  localparam int RW = D_WIDTH + 2;
  localparam int CW = $clog2(NW + 1);
  localparam int QB = NW - 1;

  logic signed [RW-1:0] rem, shifted, den_ext, rem_next;
  logic [D_WIDTH-1:0]   den;
  logic [NW-1:0]        num_sh;
  logic [QB-1:0]        q_bits;
  logic [CW-1:0]        cnt;
  logic                 busy_q;

  always_comb begin
    shifted  = {rem[RW-2:0], num_sh[NW-1]};
    den_ext  = $signed({2'b00, den});
    rem_next = rem[RW-1] ? shifted + den_ext : shifted - den_ext;
  end

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      rem    <= '0;
      den    <= '0;
      num_sh <= '0;
      q_bits <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      rem    <= '0;
      den    <= divisor;
      num_sh <= dividend;
      q_bits <= '0;
      cnt    <= CW'(NW);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem    <= rem_next;
      num_sh <= num_sh << 1;
      q_bits <= QB'({q_bits, ~rem[RW-1]});
      cnt    <= cnt - CW'(1);
      if (cnt == CW'(1)) busy_q <= 1'b0;
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt == CW'(1));

  // Digits d in {+1,-1} give Q = 2*P - (2^NW - 1); modulo 2^NW that is {P[NW-2:0],1},
  // so the leading digit never needs storing. Negative final remainder costs one.
  assign q_mag = {q_bits, 1'b1} - NW'(rem[RW-1]);
  assign r_mag = rem[RW-1] ? rem[D_WIDTH-1:0] + den : rem[D_WIDTH-1:0];

endmodule

// File: rtl/signed_nr_divider_axis.sv
// Signed fixed-point divider with valid/ready streams, saturation and
// divide-by-zero reporting around the unsigned non-restoring core.
module signed_nr_divider_axis
  import div_pkg::*;
#(
  parameter int N_WIDTH   = 16,
  parameter int D_WIDTH   = 16,
  parameter int Q_WIDTH   = 16,
  parameter int FRAC_BITS = 0
) (
  input  logic                      aclk,
  input  logic                      resetn,
  input  logic [N_WIDTH-1:0]        s_numerator,
  input  logic [D_WIDTH-1:0]        s_denominator,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic signed [Q_WIDTH-1:0] m_quotient,
  output logic [D_WIDTH-1:0]        m_remainder,
  output logic                      m_overflow,
  output logic                      m_err_div0,
  output logic                      m_valid,
  input  logic                      m_ready
);

  localparam int     NW    = N_WIDTH + FRAC_BITS;
  localparam longint Q_MAX = sat_max(Q_WIDTH);
  localparam longint Q_MIN = sat_min(Q_WIDTH);

  div_state_e state, state_next;

  logic               accept, core_start, core_busy, core_done;
  logic               num_neg, res_neg, den_zero, in_den_zero;
  logic [N_WIDTH-1:0] num_abs;
  logic [D_WIDTH-1:0] den_abs, r_mag;
  logic [NW-1:0]      q_mag;
  longint             q_mag_l;

  logic signed [Q_WIDTH-1:0] fix_q;
  logic [D_WIDTH-1:0]        fix_r;
  logic                      fix_ovf, fix_div0;

  assign num_abs     = s_numerator[N_WIDTH-1]   ? -s_numerator   : s_numerator;
  assign den_abs     = s_denominator[D_WIDTH-1] ? -s_denominator : s_denominator;
  assign in_den_zero = (s_denominator == '0);

  nr_div_core #(.NW(NW), .D_WIDTH(D_WIDTH)) u_core (
    .aclk     (aclk),
    .resetn   (resetn),
    .start    (core_start),
    .dividend (NW'(num_abs) << FRAC_BITS),
    .divisor  (den_abs),
    .busy     (core_busy),
    .done     (core_done),
    .q_mag    (q_mag),
    .r_mag    (r_mag)
  );

  always_ff @(posedge aclk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (s_valid) state_next = in_den_zero ? FIX : RUN;
      RUN:  if (core_done) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: if (m_valid && m_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s_ready    = (state == IDLE) && !core_busy;
    accept     = s_valid && s_ready;
    core_start = accept && !in_den_zero;
  end

  // Division by zero takes the FIX step too so its result is formed in one place.
  always_comb begin
    q_mag_l  = longint'(q_mag);
    fix_q    = '0;
    fix_r    = '0;
    fix_ovf  = 1'b0;
    fix_div0 = 1'b0;
    if (den_zero) begin
      fix_div0 = 1'b1;
      fix_q    = num_neg ? Q_WIDTH'(Q_MIN) : Q_WIDTH'(Q_MAX);
    end else if (res_neg && q_mag_l > -Q_MIN) begin
      fix_ovf = 1'b1;
      fix_q   = Q_WIDTH'(Q_MIN);
    end else if (!res_neg && q_mag_l > Q_MAX) begin
      fix_ovf = 1'b1;
      fix_q   = Q_WIDTH'(Q_MAX);
    end else begin
      fix_q = res_neg ? Q_WIDTH'(-q_mag_l) : Q_WIDTH'(q_mag_l);
      fix_r = num_neg ? -r_mag : r_mag;
    end
  end

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      num_neg     <= 1'b0;
      res_neg     <= 1'b0;
      den_zero    <= 1'b0;
      m_quotient  <= '0;
      m_remainder <= '0;
      m_overflow  <= 1'b0;
      m_err_div0  <= 1'b0;
      m_valid     <= 1'b0;
    end else begin
      if (accept) begin
        num_neg    <= s_numerator[N_WIDTH-1];
        res_neg    <= s_numerator[N_WIDTH-1] ^ s_denominator[D_WIDTH-1];
        den_zero   <= in_den_zero;
        m_overflow <= 1'b0;
        m_err_div0 <= 1'b0;
      end
      if (state == FIX) begin
        m_quotient  <= fix_q;
        m_remainder <= fix_r;
        m_overflow  <= fix_ovf;
        m_err_div0  <= fix_div0;
      end
      m_valid <= (state == DONE) && !(m_valid && m_ready);
    end
  end

endmodule

// File: tb/tb_signed_nr_divider_axis.sv
// Directed and random checks of the signed divider against an arithmetic model,
// using a default instance and a FRAC_BITS=8 instance.
module tb_signed_nr_divider_axis;
  import div_pkg::*;

  logic aclk = 1'b0;
  logic resetn = 1'b0;

  logic signed [15:0] s_num[2], s_den[2], m_q[2];
  logic [15:0]        m_r[2];
  logic               s_valid[2], s_ready[2], m_ovf[2], m_dz[2], m_valid[2], m_ready[2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 aclk = ~aclk;

  signed_nr_divider_axis dut0 (
    .aclk(aclk), .resetn(resetn),
    .s_numerator(s_num[0]), .s_denominator(s_den[0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
    .m_quotient(m_q[0]), .m_remainder(m_r[0]), .m_overflow(m_ovf[0]), .m_err_div0(m_dz[0]),
    .m_valid(m_valid[0]), .m_ready(m_ready[0])
  );

  signed_nr_divider_axis #(.FRAC_BITS(8)) dut8 (
    .aclk(aclk), .resetn(resetn),
    .s_numerator(s_num[1]), .s_denominator(s_den[1]), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
    .m_quotient(m_q[1]), .m_remainder(m_r[1]), .m_overflow(m_ovf[1]), .m_err_div0(m_dz[1]),
    .m_valid(m_valid[1]), .m_ready(m_ready[1])
  );

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // q = trunc(num*2^f/den), remainder follows the dividend sign, then saturate.
  function automatic void model(input longint num, input longint den, input int f,
                                output longint q, output longint r, output logic ovf, output logic dz);
    longint dv;
    ovf = 1'b0;
    dz  = 1'b0;
    if (den == 0) begin
      dz = 1'b1;
      r  = 0;
      q  = (num >= 0) ? 32767 : -32768;
    end else begin
      dv = num * (64'sd1 <<< f);
      q  = dv / den;
      r  = dv % den;
      if (q > 32767)  begin q = 32767;  r = 0; ovf = 1'b1; end
      if (q < -32768) begin q = -32768; r = 0; ovf = 1'b1; end
    end
  endfunction

  task automatic run(input int sel, input longint num, input longint den, input int hold);
    longint eq, er;
    logic eo, ed, busy_ok;
    int f, k, lat;
    logic [33:0] held;
    f = sel ? 8 : 0;
    model(num, den, f, eq, er, eo, ed);
    lat = (den == 0) ? 2 : div_latency(16, f);

    k = 0;
    while (!s_ready[sel] && k < 100) begin @(posedge aclk); #1; k++; end
    check("idle_ready", s_ready[sel], 1);

    s_num[sel]   = 16'(num);
    s_den[sel]   = 16'(den);
    s_valid[sel] = 1'b1;
    m_ready[sel] = 1'b0;
    @(posedge aclk); #1;
    s_valid[sel] = 1'b0;

    k = 0;
    busy_ok = 1'b1;
    while (!m_valid[sel] && k < 200) begin
      if (s_ready[sel]) busy_ok = 1'b0;
      @(posedge aclk); #1;
      k++;
    end
    if (s_ready[sel]) busy_ok = 1'b0;
    check("latency", k, lat);
    check("busy_not_ready", busy_ok, 1);
    check("quotient", m_q[sel], eq);
    check("remainder", $signed(m_r[sel]), er);
    check("overflow", m_ovf[sel], eo);
    check("div0", m_dz[sel], ed);

    held = {m_q[sel], m_r[sel], m_ovf[sel], m_dz[sel]};
    for (int h = 0; h < hold; h++) begin
      s_num[sel]   = 16'($urandom);
      s_den[sel]   = 16'($urandom);
      s_valid[sel] = 1'b1;
      @(posedge aclk); #1;
      check("hold_valid", m_valid[sel], 1);
      check("hold_ready", s_ready[sel], 0);
      check("hold_outputs", {m_q[sel], m_r[sel], m_ovf[sel], m_dz[sel]}, held);
    end
    s_valid[sel] = 1'b0;

    m_ready[sel] = 1'b1;
    @(posedge aclk); #1;
    check("valid_drop", m_valid[sel], 0);
    check("ready_return", s_ready[sel], 1);
    m_ready[sel] = 1'b0;
  endtask

  initial begin
    logic signed [15:0] rn, rd;
    int sel, pick;
    for (int i = 0; i < 2; i++) begin
      s_num[i] = '0; s_den[i] = '0; s_valid[i] = 1'b0; m_ready[i] = 1'b0;
    end

    repeat (3) @(posedge aclk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_ready", s_ready[i], 1);
      check("rst_valid", m_valid[i], 0);
      check("rst_outputs", {m_q[i], m_r[i], m_ovf[i], m_dz[i]}, 0);
    end
    resetn = 1'b1;
    @(posedge aclk); #1;

    run(0, 100, 7, 0);
    run(0, -100, 7, 0);
    run(0, 100, -7, 0);
    run(0, -100, -7, 0);
    run(0, -32768, -1, 0);
    run(0, -32768, 1, 0);
    run(0, 32767, -32768, 0);
    run(0, 5, 0, 0);
    run(0, -5, 0, 0);
    run(1, 1, 3, 0);
    run(1, -1, 3, 0);
    run(1, 200, 1, 0);
    run(0, 100, 7, 5);

    s_num[0] = 16'sd100; s_den[0] = 16'sd7; s_valid[0] = 1'b1;
    @(posedge aclk); #1;
    s_valid[0] = 1'b0;
    repeat (5) @(posedge aclk);
    #1;
    resetn = 1'b0;
    @(posedge aclk); #1;
    check("midrst_ready", s_ready[0], 1);
    check("midrst_valid", m_valid[0], 0);
    check("midrst_outputs", {m_q[0], m_r[0], m_ovf[0], m_dz[0]}, 0);
    resetn = 1'b1;
    run(0, 100, 7, 0);

    for (int i = 0; i < 24; i++) begin
      sel  = i % 2;
      rn   = 16'($urandom);
      pick = $urandom_range(0, 9);
      if (pick == 0)     rd = '0;
      else if (pick < 5) rd = 16'(int'($urandom_range(0, 40)) - 20);
      else               rd = 16'($urandom);
      run(sel, rn, rd, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
